sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
Shares the single SDRAM controller port between two masters:
- m0, the ADC capture/write master.
- m1, the host readback master.

Burst-locked grants are decided by fixed priority or round-robin. In-flight reads are tracked in a small tag FIFO so that each read response is returned to the master that issued it. The block sits between the ADC master, the readback logic and the SDRAM controller.

Parameters:
ADDR_W, 32, address width of masters and SDRAM port
MAX_BURST, 128, max transfers accepted per grant before forced re-arbitration (>=1)
MAX_PENDING, 4, max outstanding reads (tag FIFO depth, power of 2)
M0_PRIORITY, 1, 1 = m0 wins ties always; 0 = round-robin on ties

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
m0_req, m1_req  in  1  master requests/holds the port
m0_write, m1_write  in  1  write command valid
m0_read, m1_read  in  1  read command valid
m0_address, m1_address  in  ADDR_W  word address
m0_writedata, m1_writedata  in  16  write data
m0_byteenable, m1_byteenable  in  2  byte enables
m0_waitrequest, m1_waitrequest  out  1  command not accepted this cycle
m0_readdatavalid, m1_readdatavalid  out  1  response for this master
m_readdata  out  16  read data, broadcast to both masters
sd_address  out  ADDR_W  to SDRAM controller
sd_write, sd_read  out  1  to SDRAM controller
sd_writedata  out  16  to SDRAM controller
sd_byteenable  out  2  to SDRAM controller
sd_waitrequest  in  1  from SDRAM controller
sd_readdata  in  16  from SDRAM controller
sd_readdatavalid  in  1  from SDRAM controller
grant  out  2  one-hot current owner, 00 = none
orphan_rsp  out  1  sticky: readdatavalid arrived with empty tag FIFO

Behaviour:
Reset:
- Clock is clk; reset is synchronous, active-low on reset_n.
- While reset_n=0: grant=00, burst counter=0, tag FIFO emptied, orphan_rsp=0, rr pointer=m0.
- All sd_read/sd_write and mN_readdatavalid = 0; mN_waitrequest=1.

State machine:
- States are IDLE, OWN0, OWN1 (registered).
- IDLE: if only one mN_req is set, go to OWNn next cycle. If both are set: m0 when M0_PRIORITY=1, else the rr-pointer master. No requests: stay in IDLE.
- The arbitration decision costs 1 cycle. The first command can be accepted in the cycle after the grant.

Command path while in OWNn:
- sd_* outputs = master n's command signals, combinationally muxed.
- The non-owner always sees waitrequest=1.

Acceptance:
- A cycle with (read|write) and mN_waitrequest=0 counts as a transfer.
- mN_waitrequest = sd_waitrequest | (mN_read & tag_full).
- When tag_full=1, sd_read is forced to 0.

Burst counter:
- Increments per accepted transfer. Width is clog2(MAX_BURST+1).

Release from OWNn occurs when either:
- mN_req=0 (checked in a cycle with no accepted transfer), or
- the counter reaches MAX_BURST on an accepted transfer.

On release:
- Counter clears and rr pointer moves to the other master.
- If the other master is requesting, go directly to OWN(other). Otherwise go to IDLE.
- A forced release with no competitor re-grants the same master through IDLE (1 bubble).

Tag FIFO:
- Pushes the owner id on every accepted read.
- Pops on sd_readdatavalid.
- mN_readdatavalid = sd_readdatavalid & (head==n).
- m_readdata = sd_readdata.
- Push and pop in the same cycle are both applied; count unchanged.
- A pop while empty sets orphan_rsp and asserts no readdatavalid.

Other rules:
- Writes never touch the FIFO.
- Reads remain routable after a grant switch.
- Reset mid-operation discards pending tags. Responses arriving later flag orphan_rsp.

Decomposition:
- Shared package sdram_arb_pkg: state encodings (IDLE, OWN0, OWN1), master id constants, clog2 helper.
- One sub-module: sdram_arb_tag_fifo (1-bit-wide, MAX_PENDING deep; push/pop/full/empty/head).

Test Plan:
- m0 only, 4 writes, sd_waitrequest=0 → grant=01 one cycle after req. 4 sd_write pulses at addresses 0..3. grant=00 after m0_req drops.
- Both request in the same cycle, M0_PRIORITY=0, rr=m0 → m0 owns first. After m0 drops req, grant goes directly 01→10 with no IDLE cycle.
- MAX_BURST=4, m0 streams continuously while m1 waits → exactly 4 m0 transfers, then grant=10. m1's transfers follow, then grant returns to m0.
- m0 issues 2 reads, switch to m1 issuing 2 reads, controller returns 4 responses with latency 3 → readdatavalid pulses go to m0, m0, m1, m1 in order, with matching data.
- MAX_PENDING=4, 5 back-to-back reads with no responses → 5th read is held (waitrequest=1, sd_read=0) until the first response arrives, then accepted.
- Assert reset_n=0 for 1 cycle with 2 reads pending, then deliver 2 responses → no readdatavalid asserted, orphan_rsp=1, grant=00.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
package sdram_arb_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned BE_W   = 2;

   // Master identifiers, also the payload stored in the read tag FIFO
   localparam logic M0_ID = 1'b0;
   localparam logic M1_ID = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   // Command qualifiers and write payload of one master
   typedef struct packed {
      logic              write;
      logic              read;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } cmd_ctl_t;

   // Ceiling log2, minimum result 0
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Ordered record of which master owns each outstanding read.
module sdram_arb_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push_i,
   input  logic push_id_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o,
   output logic head_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = clog2(DEPTH + 1);

   logic [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointer wrap and occupancy update; simultaneous push/pop keeps the count
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Storage and pointer registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) mem_q[wr_ptr_q] <= push_id_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Burst-locked two-master arbiter in front of one SDRAM controller port.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned MAX_BURST   = 128,
   parameter int unsigned MAX_PENDING = 4,
   parameter int unsigned M0_PRIORITY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_write,
   input  logic              m1_write,
   input  logic              m0_read,
   input  logic              m1_read,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [15:0]       m0_writedata,
   input  logic [15:0]       m1_writedata,
   input  logic [1:0]        m0_byteenable,
   input  logic [1:0]        m1_byteenable,
   output logic              m0_waitrequest,
   output logic              m1_waitrequest,
   output logic              m0_readdatavalid,
   output logic              m1_readdatavalid,
   output logic [15:0]       m_readdata,
   output logic [ADDR_W-1:0] sd_address,
   output logic              sd_write,
   output logic              sd_read,
   output logic [15:0]       sd_writedata,
   output logic [1:0]        sd_byteenable,
   input  logic              sd_waitrequest,
   input  logic [15:0]       sd_readdata,
   input  logic              sd_readdatavalid,
   output logic [1:0]        grant,
   output logic              orphan_rsp
);

   localparam int unsigned CNT_W = clog2(MAX_BURST + 1);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic             rr_q, rr_d;
   logic             orphan_q, orphan_d;

   logic             own0, own1, own_any;
   cmd_ctl_t         m0_cmd, m1_cmd, own_cmd;
   logic             own_req, other_req;
   logic             own_wait, accept;
   logic             tag_full, tag_empty, tag_head;
   logic             rsp_ok;

   // Ownership decode, forced idle while reset is held
   assign own0    = reset_n & (state_q == OWN0);
   assign own1    = reset_n & (state_q == OWN1);
   assign own_any = own0 | own1;
   assign grant   = {own1, own0};

   // Command mux towards the controller
   assign m0_cmd     = '{write: m0_write, read: m0_read, wdata: m0_writedata, be: m0_byteenable};
   assign m1_cmd     = '{write: m1_write, read: m1_read, wdata: m1_writedata, be: m1_byteenable};
   assign own_cmd    = own1 ? m1_cmd : m0_cmd;
   assign own_req    = own1 ? m1_req : m0_req;
   assign other_req  = own1 ? m0_req : m1_req;

   assign sd_address    = own1 ? m1_address : m0_address;
   assign sd_writedata  = own_cmd.wdata;
   assign sd_byteenable = own_cmd.be;
   assign sd_write      = own_any & own_cmd.write;
   assign sd_read       = own_any & own_cmd.read & ~tag_full;

   // Reads stall while every tag slot is occupied
   assign own_wait       = sd_waitrequest | (own_cmd.read & tag_full);
   assign m0_waitrequest = ~own0 | own_wait;
   assign m1_waitrequest = ~own1 | own_wait;
   assign accept         = own_any & (own_cmd.read | own_cmd.write) & ~own_wait;

   // Response steering by the oldest outstanding tag
   assign rsp_ok           = reset_n & sd_readdatavalid & ~tag_empty;
   assign m0_readdatavalid = rsp_ok & (tag_head == M0_ID);
   assign m1_readdatavalid = rsp_ok & (tag_head == M1_ID);
   assign m_readdata       = sd_readdata;
   assign orphan_rsp       = orphan_q;

   sdram_arb_tag_fifo #(
      .DEPTH (MAX_PENDING)
   ) u_tag_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push_i    (accept & own_cmd.read),
      .push_id_i (own1 ? M1_ID : M0_ID),
      .pop_i     (sd_readdatavalid),
      .full_o    (tag_full),
      .empty_o   (tag_empty),
      .head_o    (tag_head)
   );

   // Grant decision, burst accounting and release handover
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      rr_d        = rr_q;
      orphan_d    = orphan_q | (sd_readdatavalid & tag_empty);
      unique case (state_q)
         IDLE: begin
            if (m0_req && m1_req) begin
               state_d = ((M0_PRIORITY != 0) || (rr_q == M0_ID)) ? OWN0 : OWN1;
            end else if (m0_req) begin
               state_d = OWN0;
            end else if (m1_req) begin
               state_d = OWN1;
            end
         end
         OWN0, OWN1: begin
            if (accept) burst_cnt_d = burst_cnt_q + CNT_W'(1);
            if ((accept && (burst_cnt_q == CNT_W'(MAX_BURST - 1))) || (!accept && !own_req)) begin
               burst_cnt_d = '0;
               rr_d        = (state_q == OWN0) ? M1_ID : M0_ID;
               if (other_req) state_d = (state_q == OWN0) ? OWN1 : OWN0;
               else           state_d = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            burst_cnt_d = '0;
         end
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         burst_cnt_q <= '0;
         rr_q        <= M0_ID;
         orphan_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         rr_q        <= rr_d;
         orphan_q    <= orphan_d;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: MAX_BURST=4, MAX_PENDING=4, round-robin ties.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  m_req, m_wr, m_rd, m_wait, m_rdv;
   logic [31:0] m_addr [2];
   logic [15:0] m_wd   [2];
   logic [1:0]  m_be   [2];
   logic [15:0] m_readdata;
   logic [31:0] sd_address;
   logic        sd_write, sd_read;
   logic [15:0] sd_writedata;
   logic [1:0]  sd_byteenable;
   logic        sd_waitrequest;
   logic [15:0] sd_readdata;
   logic        sd_readdatavalid;
   logic [1:0]  grant;
   logic        orphan_rsp;

   typedef struct { bit m; bit wr; logic [31:0] addr; logic [15:0] wd; logic [1:0] be; } cmd_t;
   typedef struct { bit m; logic [15:0] d; } rsp_t;
   typedef struct { int due; logic [15:0] d; } ctl_t;

   cmd_t exp_cmd[$];
   rsp_t exp_rsp[$];
   ctl_t rq[$];
   logic own_log[$];
   int   n_cmp = 0, n_err = 0;
   int   cyc = 0, rsp_seen = 0, n_rd_acc = 0;
   bit   ctl_hold = 1'b0;

   always #5 clk = ~clk;

   sdram_port_arbiter #(
      .ADDR_W(32), .MAX_BURST(4), .MAX_PENDING(4), .M0_PRIORITY(0)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m_req[0]), .m1_req(m_req[1]),
      .m0_write(m_wr[0]), .m1_write(m_wr[1]),
      .m0_read(m_rd[0]), .m1_read(m_rd[1]),
      .m0_address(m_addr[0]), .m1_address(m_addr[1]),
      .m0_writedata(m_wd[0]), .m1_writedata(m_wd[1]),
      .m0_byteenable(m_be[0]), .m1_byteenable(m_be[1]),
      .m0_waitrequest(m_wait[0]), .m1_waitrequest(m_wait[1]),
      .m0_readdatavalid(m_rdv[0]), .m1_readdatavalid(m_rdv[1]),
      .m_readdata(m_readdata),
      .sd_address(sd_address), .sd_write(sd_write), .sd_read(sd_read),
      .sd_writedata(sd_writedata), .sd_byteenable(sd_byteenable),
      .sd_waitrequest(sd_waitrequest), .sd_readdata(sd_readdata),
      .sd_readdatavalid(sd_readdatavalid),
      .grant(grant), .orphan_rsp(orphan_rsp)
   );

   function automatic logic [15:0] rdata(input logic [31:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // {count, bit i = 1 when transfer i was owned by m1}
   function automatic logic [31:0] own_code();
      logic [15:0] b;
      b = '0;
      foreach (own_log[i]) if (i < 16) b[i] = own_log[i];
      return {16'(own_log.size()), b};
   endfunction

   // Controller model: read latency 3, responses withheld while ctl_hold is set
   initial begin
      ctl_t c;
      sd_readdatavalid = 1'b0;
      sd_readdata      = '0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         sd_readdatavalid = 1'b0;
         if (!ctl_hold && rq.size() > 0 && rq[0].due <= cyc) begin
            c = rq.pop_front();
            sd_readdatavalid = 1'b1;
            sd_readdata      = c.d;
         end
      end
   end

   // Controller side: capture accepted reads
   initial begin
      ctl_t c;
      forever begin
         @(negedge clk);
         if (sd_read && !sd_waitrequest) begin
            c.due = cyc + 3;
            c.d   = rdata(sd_address);
            rq.push_back(c);
         end
      end
   end

   // Monitor: compare accepted commands and routed responses against the scoreboard
   initial begin
      cmd_t e;
      rsp_t r;
      forever begin
         @(negedge clk); #2;
         if ((sd_write || sd_read) && !sd_waitrequest) begin
            own_log.push_back(grant[1]);
            if (sd_read) n_rd_acc++;
            if (exp_cmd.size() == 0) begin
               chk("cmd_unexpected", 32'(sd_address), 32'hFFFF_FFFF);
            end else begin
               e = exp_cmd.pop_front();
               chk("cmd_owner", 32'(grant), e.m ? 32'd2 : 32'd1);
               chk("cmd_kind", 32'({sd_write, sd_read}), e.wr ? 32'd2 : 32'd1);
               chk("cmd_addr", sd_address, e.addr);
               chk("cmd_wdata", 32'(sd_writedata), 32'(e.wd));
               chk("cmd_be", 32'(sd_byteenable), 32'(e.be));
            end
         end
         if (m_rdv != 2'b00) begin
            rsp_seen++;
            if (exp_rsp.size() == 0) begin
               chk("rsp_unexpected", 32'(m_rdv), 32'd0);
            end else begin
               r = exp_rsp.pop_front();
               chk("rsp_route", 32'(m_rdv), r.m ? 32'd2 : 32'd1);
               chk("rsp_data", 32'(m_readdata), 32'(r.d));
            end
         end
      end
   end

   // One master issuing n back-to-back commands while holding req
   task automatic master_run(input int m, input int n, input bit wr, input logic [31:0] base,
                             output int first_wait, output int tot_wait);
      int   w;
      cmd_t e;
      rsp_t r;
      first_wait = -1;
      tot_wait   = 0;
      @(posedge clk); #1;
      m_req[m] = 1'b1;
      for (int i = 0; i < n; i++) begin
         m_wr[m]   = wr;
         m_rd[m]   = !wr;
         m_addr[m] = base + 32'(i);
         m_wd[m]   = 16'hC000 + 16'(i) + ((m == 1) ? 16'h0100 : 16'h0000);
         m_be[m]   = 2'(i + 1);
         w = 0;
         forever begin
            @(negedge clk);
            if (!m_wait[m]) break;
            w++;
            if (w >= 200) break;
         end
         if (i == 0) first_wait = w;
         tot_wait += w;
         if (m_wait[m]) begin
            chk("accept_timeout", 32'(w), 32'd0);
            break;
         end
         e.m = (m == 1); e.wr = wr; e.addr = m_addr[m]; e.wd = m_wd[m]; e.be = m_be[m];
         exp_cmd.push_back(e);
         if (!wr) begin
            r.m = (m == 1); r.d = rdata(m_addr[m]);
            exp_rsp.push_back(r);
         end
         @(posedge clk); #1;
      end
      m_wr[m]  = 1'b0;
      m_rd[m]  = 1'b0;
      m_req[m] = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
   endtask

   task automatic drain_rsp(input string nm);
      int k;
      k = 0;
      while (exp_rsp.size() > 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk(nm, 32'(exp_rsp.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int fw0, tw0, fw1, tw1, base_seen, base_acc, k;
      reset_n = 1'b0;
      sd_waitrequest = 1'b0;
      m_req = 2'b11; m_rd = 2'b11; m_wr = 2'b00;
      for (int i = 0; i < 2; i++) begin
         m_addr[i] = '0; m_wd[i] = '0; m_be[i] = '0;
      end

      // Reset with both masters asserting reads
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_wait", 32'(m_wait), 32'd3);
      chk("rst_sdcmd", 32'({sd_read, sd_write}), 32'd0);
      chk("rst_rdv", 32'(m_rdv), 32'd0);
      chk("rst_orphan", 32'(orphan_rsp), 32'd0);
      @(posedge clk); #1;
      m_req = 2'b00; m_rd = 2'b00;
      reset_n = 1'b1;

      // m0 alone: 4 writes, controller stalls the second one for 2 cycles
      own_log.delete();
      fork
         master_run(0, 4, 1'b1, 32'h0, fw0, tw0);
         begin
            repeat (3) @(posedge clk);
            #1 sd_waitrequest = 1'b1;
            repeat (2) @(posedge clk);
            #1 sd_waitrequest = 1'b0;
         end
      join
      chk("t1_first_wait", 32'(fw0), 32'd1);
      chk("t1_total_wait", 32'(tw0), 32'd3);
      repeat (2) @(negedge clk);
      chk("t1_grant_idle", 32'(grant), 32'd0);
      chk("t1_owners", own_code(), 32'h0004_0000);

      // Simultaneous requests, round-robin pointer at m0, direct handover
      do_reset();
      own_log.delete();
      fork
         master_run(0, 2, 1'b1, 32'h100, fw0, tw0);
         master_run(1, 2, 1'b1, 32'h200, fw1, tw1);
      join
      chk("t2_m0_first_wait", 32'(fw0), 32'd1);
      chk("t2_m1_first_wait", 32'(fw1), 32'd4);
      chk("t2_owners", own_code(), 32'h0004_000C);
      repeat (2) @(negedge clk);
      chk("t2_grant_idle", 32'(grant), 32'd0);

      // Burst limit: m0 streams 6 writes, m1 joins and takes over after 4
      own_log.delete();
      fork
         master_run(0, 6, 1'b1, 32'h300, fw0, tw0);
         begin
            repeat (2) @(posedge clk);
            master_run(1, 2, 1'b1, 32'h400, fw1, tw1);
         end
      join
      chk("t3_owners", own_code(), 32'h0008_0030);
      chk("t3_m1_first_wait", 32'(fw1), 32'd3);
      chk("t3_m0_total_wait", 32'(tw0), 32'd4);
      repeat (2) @(negedge clk);
      chk("t3_grant_idle", 32'(grant), 32'd0);
      chk("t3_cmd_left", 32'(exp_cmd.size()), 32'd0);

      // Reads from both masters, responses routed after the grant switch
      base_seen = rsp_seen;
      master_run(0, 2, 1'b0, 32'h500, fw0, tw0);
      master_run(1, 2, 1'b0, 32'h600, fw1, tw1);
      drain_rsp("t4_drain");
      chk("t4_rsp_count", 32'(rsp_seen - base_seen), 32'd4);

      // Tag FIFO full: fifth read held until the first response
      do_reset();
      base_acc = n_rd_acc;
      ctl_hold = 1'b1;
      fork
         master_run(0, 5, 1'b0, 32'h700, fw0, tw0);
         begin
            repeat (14) @(negedge clk);
            chk("t5_grant_held", 32'(grant), 32'd1);
            chk("t5_wait_full", 32'(m_wait[0]), 32'd1);
            chk("t5_sdread_off", 32'(sd_read), 32'd0);
            chk("t5_acc_before", 32'(n_rd_acc - base_acc), 32'd4);
            @(posedge clk); #1 ctl_hold = 1'b0;
         end
      join
      drain_rsp("t5_drain");
      chk("t5_acc_after", 32'(n_rd_acc - base_acc), 32'd5);

      // Reset with 2 reads pending: late responses become orphans
      do_reset();
      ctl_hold = 1'b1;
      master_run(0, 2, 1'b0, 32'h800, fw0, tw0);
      repeat (2) @(negedge clk);
      chk("t6_orphan_pre", 32'(orphan_rsp), 32'd0);
      @(posedge clk); #1 reset_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_wait", 32'(m_wait), 32'd3);
      chk("t6_rst_grant", 32'(grant), 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      exp_rsp.delete();
      base_seen = rsp_seen;
      ctl_hold = 1'b0;
      k = 0;
      while (rq.size() > 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      chk("t6_ctl_drained", 32'(rq.size()), 32'd0);
      chk("t6_orphan", 32'(orphan_rsp), 32'd1);
      chk("t6_grant", 32'(grant), 32'd0);
      chk("t6_no_rdv", 32'(rsp_seen - base_seen), 32'd0);

      chk("end_cmd_left", 32'(exp_cmd.size()), 32'd0);
      chk("end_rsp_left", 32'(exp_rsp.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
